// File: rtl/fixed_point_pkg.sv
// Shared constants and types for the fixed-point datapath blocks.
// FIXED_DIV_ROUND_EN adds a guard quotient bit for round-half-up division.
package fixed_point_pkg;

   localparam int unsigned DATA_W    = 16;
   localparam int unsigned FRAC_BITS = DATA_W / 2;

   localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FINISH
   } div_state_t;

   // Quotient bits produced by the divider for an n-bit word.
   function automatic int unsigned calc_iter(int unsigned n);
`ifdef FIXED_DIV_ROUND_EN
      return (3 * n) / 2 + 1;
`else
      return (3 * n) / 2;
`endif
   endfunction

   localparam int unsigned ITER = calc_iter(DATA_W);

endpackage

// File: rtl/fixed_point_saturate.sv
// Sign restore and clamp of an unsigned magnitude to an N-bit two's complement result.
module fixed_point_saturate #(
   parameter int unsigned N  = 16,
   parameter int unsigned MW = 3 * N / 2 + 1
) (
   input  logic [MW-1:0] mag,
   input  logic          neg,
   output logic [N-1:0]  result,
   output logic          overflow
);

   localparam logic [N-1:0]  MAX_VAL = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]  MIN_VAL = {1'b1, {(N-1){1'b0}}};
   localparam logic [MW-1:0] POS_LIM = {{(MW-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic [MW-1:0] NEG_LIM = POS_LIM + MW'(1);

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      if (neg) begin
         if (mag > NEG_LIM) begin
            result   = MIN_VAL;
            overflow = 1'b1;
         end else begin
            // A magnitude of exactly 2^(N-1) negates to MIN_VAL without overflow.
            result = '0 - mag[N-1:0];
         end
      end else begin
         if (mag > POS_LIM) begin
            result   = MAX_VAL;
            overflow = 1'b1;
         end else begin
            result = mag[N-1:0];
         end
      end
   end

endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed Q(N/2).(N/2) restoring divider with start/busy/done handshake.
// Define FIXED_DIV_ROUND_EN for round-half-up instead of truncation toward zero.
module fixed_point_divider
   import fixed_point_pkg::*;
#(
   parameter int unsigned N = DATA_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic         overflow,
   output logic         div_by_zero
);

   localparam int unsigned IT = calc_iter(N);
   localparam int unsigned MW = 3 * N / 2 + 1;
   localparam int unsigned CW = $clog2(IT + 1);

   localparam logic [N-1:0] MAX_VAL = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

   div_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  rem_q, rem_d;
   logic [IT-1:0] nq_q, nq_d;
   logic [N-1:0]  dvs_q, dvs_d;
   logic          neg_q, neg_d;
   logic          dvs_zero_q, dvs_zero_d;
   logic          dvd_zero_q, dvd_zero_d;
   logic [N-1:0]  quo_q, quo_d;
   logic          ovf_q, ovf_d;
   logic          dbz_q, dbz_d;
   logic          done_q, done_d;

   logic [N-1:0]  abs_dvd, abs_dvs;
   logic [N:0]    rem_shift, diff;
   logic          ge;
   logic [MW-1:0] mag;
   logic [N-1:0]  sat_res;
   logic          sat_ovf;

   assign abs_dvd = dividend[N-1] ? ('0 - dividend) : dividend;
   assign abs_dvs = divisor[N-1] ? ('0 - divisor) : divisor;

   // nq holds the unconsumed numerator bits at the top and collects quotient bits at the bottom.
   assign rem_shift = {rem_q, nq_q[IT-1]};
   assign diff      = rem_shift - {1'b0, dvs_q};
   assign ge        = rem_shift >= {1'b0, dvs_q};

`ifdef FIXED_DIV_ROUND_EN
   assign mag = MW'(nq_q[IT-1:1]) + MW'(nq_q[0]);
`else
   assign mag = MW'(nq_q);
`endif

   fixed_point_saturate #(
      .N  (N),
      .MW (MW)
   ) u_saturate (
      .mag      (mag),
      .neg      (neg_q),
      .result   (sat_res),
      .overflow (sat_ovf)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      nq_d       = nq_q;
      dvs_d      = dvs_q;
      neg_d      = neg_q;
      dvs_zero_d = dvs_zero_q;
      dvd_zero_d = dvd_zero_q;
      quo_d      = quo_q;
      ovf_d      = ovf_q;
      dbz_d      = dbz_q;
      done_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               nq_d       = {abs_dvd, {(IT-N){1'b0}}};
               rem_d      = '0;
               dvs_d      = abs_dvs;
               neg_d      = dividend[N-1] ^ divisor[N-1];
               dvs_zero_d = (divisor == '0);
               dvd_zero_d = (dividend == '0);
               cnt_d      = '0;
               state_d    = CALC;
            end
         end
         CALC: begin
            rem_d = ge ? diff[N-1:0] : rem_shift[N-1:0];
            nq_d  = {nq_q[IT-2:0], ge};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(IT - 1)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (dvs_zero_q) begin
               // With a zero divisor the sign register carries the dividend sign alone.
               quo_d = dvd_zero_q ? '0 : (neg_q ? MIN_VAL : MAX_VAL);
               ovf_d = 1'b0;
               dbz_d = 1'b1;
            end else begin
               quo_d = sat_res;
               ovf_d = sat_ovf;
               dbz_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         nq_q       <= '0;
         dvs_q      <= '0;
         neg_q      <= 1'b0;
         dvs_zero_q <= 1'b0;
         dvd_zero_q <= 1'b0;
         quo_q      <= '0;
         ovf_q      <= 1'b0;
         dbz_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         nq_q       <= nq_d;
         dvs_q      <= dvs_d;
         neg_q      <= neg_d;
         dvs_zero_q <= dvs_zero_d;
         dvd_zero_q <= dvd_zero_d;
         quo_q      <= quo_d;
         ovf_q      <= ovf_d;
         dbz_q      <= dbz_d;
         done_q     <= done_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign quotient    = quo_q;
   assign overflow    = ovf_q;
   assign div_by_zero = dbz_q;

endmodule
